// File: rtl/shared_event_fifo.sv
// Shared event FIFO between the event router and the comms controller.
// It stores each event with an odd-parity bit and reports occupancy, a high-water mark and a sticky overflow flag.
module shared_event_fifo #(
    parameter int WIDTH      = 64,
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_BITS  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-2:0]     channel_event_in,
    input  logic                 load_event,
    input  logic                 read_fifo_n,
    input  logic                 clear_flags,
    output logic [WIDTH-1:0]     data_out,
    output logic                 fifo_ack,
    output logic                 fifo_empty,
    output logic                 fifo_full,
    output logic                 fifo_half,
    output logic [FIFO_BITS:0]   fifo_counter,
    output logic [FIFO_BITS:0]   high_water,
    output logic                 overflow
);

    localparam logic [FIFO_BITS:0]   CNT_DEPTH = (FIFO_BITS+1)'(FIFO_DEPTH);
    localparam logic [FIFO_BITS:0]   CNT_HALF  = (FIFO_BITS+1)'(FIFO_DEPTH / 2);
    localparam logic [FIFO_BITS:0]   CNT_ONE   = (FIFO_BITS+1)'(1);
    localparam logic [FIFO_BITS-1:0] PTR_ONE   = FIFO_BITS'(1);

    logic [WIDTH-1:0]     mem [FIFO_DEPTH];
    logic [FIFO_BITS-1:0] wr_ptr;
    logic [FIFO_BITS-1:0] rd_ptr;
    logic                 pop_accept;
    logic                 wr_accept;
    logic                 wr_drop;
    logic [FIFO_BITS:0]   cnt_next;
    logic [WIDTH-1:0]     wr_word;

    // A full FIFO still accepts a write when a pop frees a slot in the same cycle.
    always_comb begin
        pop_accept = ~read_fifo_n & ~fifo_empty;
        wr_accept  = load_event & (~fifo_full | pop_accept);
        wr_drop    = load_event & fifo_full & ~pop_accept;
        wr_word    = {~^channel_event_in, channel_event_in};
        cnt_next   = fifo_counter;
        if (wr_accept && !pop_accept)
            cnt_next = fifo_counter + CNT_ONE;
        else if (pop_accept && !wr_accept)
            cnt_next = fifo_counter - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (wr_accept)
            mem[wr_ptr] <= wr_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_counter <= '0;
            high_water   <= '0;
            overflow     <= 1'b0;
            data_out     <= '0;
            fifo_ack     <= 1'b0;
            fifo_empty   <= 1'b1;
            fifo_full    <= 1'b0;
            fifo_half    <= 1'b0;
        end else begin
            fifo_ack <= pop_accept;
            if (pop_accept) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + PTR_ONE;
            end
            if (wr_accept)
                wr_ptr <= wr_ptr + PTR_ONE;

            fifo_counter <= cnt_next;
            fifo_empty   <= (cnt_next == '0);
            fifo_full    <= (cnt_next == CNT_DEPTH);
            fifo_half    <= (cnt_next >= CNT_HALF);

            if (clear_flags || cnt_next > high_water)
                high_water <= cnt_next;

            // A drop in the same cycle as a clear leaves overflow set.
            if (wr_drop)
                overflow <= 1'b1;
            else if (clear_flags)
                overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shared_event_fifo.sv
// Directed self-checking bench for shared_event_fifo.
module tb_shared_event_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic [62:0] channel_event_in;
    logic        load_event;
    logic        read_fifo_n;
    logic        clear_flags;
    logic [63:0] data_out;
    logic        fifo_ack;
    logic        fifo_empty;
    logic        fifo_full;
    logic        fifo_half;
    logic [4:0]  fifo_counter;
    logic [4:0]  high_water;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    shared_event_fifo #(.WIDTH(64), .FIFO_DEPTH(16), .FIFO_BITS(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .channel_event_in (channel_event_in),
        .load_event       (load_event),
        .read_fifo_n      (read_fifo_n),
        .clear_flags      (clear_flags),
        .data_out         (data_out),
        .fifo_ack         (fifo_ack),
        .fifo_empty       (fifo_empty),
        .fifo_full        (fifo_full),
        .fifo_half        (fifo_half),
        .fifo_counter     (fifo_counter),
        .high_water       (high_water),
        .overflow         (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mk(input logic [62:0] e);
        return {~^e, e};
    endfunction

    initial begin
        reset = 1'b1; channel_event_in = '0; load_event = 1'b0;
        read_fifo_n = 1'b1; clear_flags = 1'b0;
        step(); step();
        reset = 1'b0;
        check("rst_empty", 64'(fifo_empty), 64'd1);
        check("rst_full", 64'(fifo_full), 64'd0);
        check("rst_half", 64'(fifo_half), 64'd0);
        check("rst_cnt", 64'(fifo_counter), 64'd0);
        check("rst_hw", 64'(high_water), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_ack", 64'(fifo_ack), 64'd0);
        check("rst_data", data_out, 64'd0);

        // pop on empty is ignored
        read_fifo_n = 1'b0; step(); read_fifo_n = 1'b1;
        check("empty_pop_ack", 64'(fifo_ack), 64'd0);

        // single event 0 -> parity 1
        channel_event_in = 63'h0; load_event = 1'b1; step(); load_event = 1'b0;
        check("t1_cnt1", 64'(fifo_counter), 64'd1);
        check("t1_empty0", 64'(fifo_empty), 64'd0);
        read_fifo_n = 1'b0; step(); read_fifo_n = 1'b1;
        check("t1_ack", 64'(fifo_ack), 64'd1);
        check("t1_data", data_out, 64'h8000_0000_0000_0000);
        check("t1_cnt0", 64'(fifo_counter), 64'd0);
        check("t1_empty1", 64'(fifo_empty), 64'd1);
        step();
        check("t1_ack_pulse", 64'(fifo_ack), 64'd0);
        check("t1_data_hold", data_out, 64'h8000_0000_0000_0000);

        // back-to-back loads, ordered pops
        load_event = 1'b1;
        channel_event_in = 63'h1; step();
        channel_event_in = 63'h3; step();
        load_event = 1'b0;
        check("t2_hw", 64'(high_water), 64'd2);
        read_fifo_n = 1'b0; step();
        check("t2_d0", data_out, 64'h0000_0000_0000_0001);
        check("t2_ack0", 64'(fifo_ack), 64'd1);
        step(); read_fifo_n = 1'b1;
        check("t2_d1", data_out, 64'h8000_0000_0000_0003);
        check("t2_ack1", 64'(fifo_ack), 64'd1);
        step();
        check("t2_ack_end", 64'(fifo_ack), 64'd0);
        check("t2_cnt", 64'(fifo_counter), 64'd0);

        // 17 loads into 16 slots -> last dropped
        load_event = 1'b1;
        for (int unsigned i = 1; i <= 17; i++) begin
            channel_event_in = 63'(i);
            step();
        end
        load_event = 1'b0;
        check("t3_full", 64'(fifo_full), 64'd1);
        check("t3_cnt", 64'(fifo_counter), 64'd16);
        check("t3_ovf", 64'(overflow), 64'd1);
        check("t3_half", 64'(fifo_half), 64'd1);
        check("t3_hw", 64'(high_water), 64'd16);

        clear_flags = 1'b1; step(); clear_flags = 1'b0;
        check("clr_ovf", 64'(overflow), 64'd0);
        check("clr_hw", 64'(high_water), 64'd16);

        // simultaneous load + pop while full
        channel_event_in = 63'd100; load_event = 1'b1; read_fifo_n = 1'b0;
        step(); load_event = 1'b0;
        check("t4_ack", 64'(fifo_ack), 64'd1);
        check("t4_data", data_out, mk(63'd1));
        check("t4_cnt", 64'(fifo_counter), 64'd16);
        check("t4_full", 64'(fifo_full), 64'd1);
        check("t4_ovf", 64'(overflow), 64'd0);

        // drain: 2..16 then 100
        for (int unsigned i = 2; i <= 17; i++) begin
            step();
            check("drain_ack", 64'(fifo_ack), 64'd1);
            check("drain_data", data_out, (i == 17) ? mk(63'd100) : mk(63'(i)));
        end
        read_fifo_n = 1'b1;
        check("drain_cnt", 64'(fifo_counter), 64'd0);
        check("drain_empty", 64'(fifo_empty), 64'd1);

        // load + pop on empty: no bypass
        channel_event_in = 63'd55; load_event = 1'b1; read_fifo_n = 1'b0;
        step(); load_event = 1'b0;
        check("t5_noack", 64'(fifo_ack), 64'd0);
        check("t5_cnt", 64'(fifo_counter), 64'd1);
        check("t5_data_hold", data_out, mk(63'd100));
        step(); read_fifo_n = 1'b1;
        check("t5_ack", 64'(fifo_ack), 64'd1);
        check("t5_data", data_out, mk(63'd55));
        check("t5_cnt0", 64'(fifo_counter), 64'd0);

        // fill to 9, clear, then reset mid-stream
        load_event = 1'b1;
        for (int unsigned i = 0; i < 9; i++) begin
            channel_event_in = 63'(200 + i);
            step();
        end
        load_event = 1'b0;
        check("t6_cnt", 64'(fifo_counter), 64'd9);
        check("t6_half", 64'(fifo_half), 64'd1);
        clear_flags = 1'b1; step(); clear_flags = 1'b0;
        check("t6_hw_clr", 64'(high_water), 64'd9);
        reset = 1'b1; read_fifo_n = 1'b0; step();
        reset = 1'b0; read_fifo_n = 1'b1;
        check("t6_rst_cnt", 64'(fifo_counter), 64'd0);
        check("t6_rst_hw", 64'(high_water), 64'd0);
        check("t6_rst_ovf", 64'(overflow), 64'd0);
        check("t6_rst_ack", 64'(fifo_ack), 64'd0);
        check("t6_rst_empty", 64'(fifo_empty), 64'd1);
        check("t6_rst_half", 64'(fifo_half), 64'd0);
        step();
        check("t6_post_ack", 64'(fifo_ack), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
